i2c_controller: RTL and testbench

I2C_CONTROLLER -- requirements
Module: i2c_controller

---
 rtl/i2c_controller.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_controller.sv
// Single-master I2C register-write controller (START, addr, reg, data, STOP).
// Define I2C_CONTROLLER_READ_EN to add register reads via repeated START.
module i2c_controller #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       read_i,
    input  logic [6:0] target_address_i,
    input  logic [7:0] register_id_i,
    input  logic [7:0] register_value_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_o,
    output logic [7:0] read_data_o,
    output logic       scl_o,
    inout  wire        sda_io
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_SEND_BYTE = 3'd2,
        ST_GET_ACK   = 3'd3,
`ifdef I2C_CONTROLLER_READ_EN
        ST_RESTART   = 3'd4,
        ST_RECV_BYTE = 3'd5,
        ST_SEND_NACK = 3'd6,
`endif
        ST_STOP      = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_div;
    logic [1:0]  r_qtr;
    logic [2:0]  r_bit;
    logic [1:0]  r_byte;
    logic [7:0]  r_tx;
    logic [6:0]  r_addr;
    logic [7:0]  r_reg;
    logic [7:0]  r_val;
    logic        r_sample;
    logic        r_nack;
    logic        r_done;
    logic        w_read;
    logic        w_tick;
    logic        w_qend;
    logic        w_bit_sample;
    logic        w_scl;
    logic        w_sda_low;

`ifdef I2C_CONTROLLER_READ_EN
    logic        r_read;
    logic [7:0]  r_rx;
    logic [7:0]  r_data;
    assign w_read      = r_read;
    assign read_data_o = r_data;
`else
    logic        w_unused_read;
    assign w_unused_read = read_i;
    assign w_read        = 1'b0;
    assign read_data_o   = 8'h00;
`endif

    assign w_tick       = (r_div == 16'(CLK_DIV - 1));
    assign w_qend       = w_tick && (r_qtr == 2'd3);
    assign w_bit_sample = w_tick && (r_qtr == 2'd2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (start_i) w_next_state = ST_START;
            ST_START:     if (w_qend) w_next_state = ST_SEND_BYTE;
            ST_SEND_BYTE: if (w_qend && r_bit == 3'd0) w_next_state = ST_GET_ACK;
            ST_GET_ACK: begin
                if (w_qend) begin
                    if (r_sample) w_next_state = ST_STOP;
`ifdef I2C_CONTROLLER_READ_EN
                    else if (r_read && r_byte == 2'd1) w_next_state = ST_RESTART;
                    else if (r_read && r_byte == 2'd2) w_next_state = ST_RECV_BYTE;
`endif
                    else if (r_byte == 2'd2) w_next_state = ST_STOP;
                    else w_next_state = ST_SEND_BYTE;
                end
            end
`ifdef I2C_CONTROLLER_READ_EN
            ST_RESTART:   if (w_qend) w_next_state = ST_SEND_BYTE;
            ST_RECV_BYTE: if (w_qend && r_bit == 3'd0) w_next_state = ST_SEND_NACK;
            ST_SEND_NACK: if (w_qend) w_next_state = ST_STOP;
`endif
            ST_STOP:      if (w_qend) w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // r_bit counts 7 down to 0 and wraps back to 7, ready for the next byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div    <= '0;
            r_qtr    <= '0;
            r_bit    <= 3'd7;
            r_byte   <= '0;
            r_tx     <= '0;
            r_addr   <= '0;
            r_reg    <= '0;
            r_val    <= '0;
            r_sample <= 1'b0;
            r_nack   <= 1'b0;
            r_done   <= 1'b0;
`ifdef I2C_CONTROLLER_READ_EN
            r_read   <= 1'b0;
            r_rx     <= '0;
            r_data   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_div <= '0;
                r_qtr <= '0;
                r_bit <= 3'd7;
                if (start_i) begin
                    r_addr <= target_address_i;
                    r_reg  <= register_id_i;
                    r_val  <= register_value_i;
                    r_tx   <= {target_address_i, 1'b0};
                    r_byte <= '0;
                    r_nack <= 1'b0;
`ifdef I2C_CONTROLLER_READ_EN
                    r_read <= read_i;
`endif
                end
            end else begin
                r_div <= w_tick ? '0 : r_div + 16'd1;
                if (w_tick) r_qtr <= r_qtr + 2'd1;
                if (w_bit_sample) begin
                    r_sample <= sda_io;
`ifdef I2C_CONTROLLER_READ_EN
                    if (r_state == ST_RECV_BYTE) r_rx <= {r_rx[6:0], sda_io};
`endif
                end
                if (w_qend) begin
                    case (r_state)
                        ST_SEND_BYTE: r_bit <= r_bit - 3'd1;
                        ST_GET_ACK: begin
                            if (r_sample) begin
                                r_nack <= 1'b1;
                            end else begin
                                r_byte <= r_byte + 2'd1;
                                case (r_byte)
                                    2'd0:    r_tx <= r_reg;
                                    2'd1:    r_tx <= w_read ? {r_addr, 1'b1} : r_val;
                                    default: r_tx <= r_tx;
                                endcase
                            end
                        end
`ifdef I2C_CONTROLLER_READ_EN
                        ST_RECV_BYTE: r_bit <= r_bit - 3'd1;
`endif
                        ST_STOP: begin
                            r_done <= 1'b1;
`ifdef I2C_CONTROLLER_READ_EN
                            if (r_read && !r_nack) r_data <= r_rx;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Bus levels per quarter: data bits have SCL high in Q2-Q3; START/RESTART/STOP shape edges.
    always_comb begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        case (r_state)
            ST_START: w_sda_low = r_qtr[1];
            ST_SEND_BYTE: begin
                w_scl     = r_qtr[1];
                w_sda_low = ~r_tx[r_bit];
            end
            ST_GET_ACK: w_scl = r_qtr[1];
`ifdef I2C_CONTROLLER_READ_EN
            ST_RECV_BYTE, ST_SEND_NACK: w_scl = r_qtr[1];
            ST_RESTART: begin
                w_scl     = (r_qtr != 2'd0);
                w_sda_low = r_qtr[1];
            end
`endif
            ST_STOP: begin
                w_scl     = (r_qtr != 2'd0);
                w_sda_low = (r_qtr != 2'd3);
            end
            default: ;
        endcase
    end

    assign scl_o  = w_scl;
    assign sda_io = w_sda_low ? 1'b0 : 1'bz;
    assign busy_o = (r_state != ST_IDLE);
    assign done_o = r_done;
    assign nack_o = r_nack;

endmodule

// File: tb/tb_i2c_controller.sv
// Directed bench for i2c_controller: bus monitor plus a target model at 7'h70.
// Bus activity is logged as tokens and compared against hand-written expected streams.
module tb_i2c_controller;

    localparam int unsigned CLK_DIV = 4;
    localparam logic [11:0] TOK_START = 12'h200;
    localparam logic [11:0] TOK_STOP  = 12'h400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       read = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] reg_id = '0;
    logic [7:0] reg_val = '0;
    logic       busy;
    logic       done;
    logic       nack;
    logic [7:0] read_data;
    logic       scl;
    wire        sda;

    logic       tgt_low = 1'b0;
    logic [6:0] tgt_addr = 7'h70;
    logic [7:0] tgt_rd_byte = 8'hA5;

    pullup (sda);
    assign sda = tgt_low ? 1'b0 : 1'bz;

    i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start),
        .read_i           (read),
        .target_address_i (addr),
        .register_id_i    (reg_id),
        .register_value_i (reg_val),
        .busy_o           (busy),
        .done_o           (done),
        .nack_o           (nack),
        .read_data_o      (read_data),
        .scl_o            (scl),
        .sda_io           (sda)
    );

    // Clock / cycle counter / watchdog
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    int cap_cyc = 0;
    int done_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    int n_checks = 0;
    int n_fail = 0;
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] tok(input logic [7:0] b, input logic ack);
        return {3'b100, b, ack};
    endfunction

    task automatic compare_bus(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // Bus monitor + target: sampled on clk negedge so SCL/SDA edges never race.
    logic scl_q = 1'b1, sda_q = 1'b1;
    logic s_now, d_now;
    logic in_frame = 1'b0, rd_mode = 1'b0, addr_ok = 1'b0;
    int   bitn = 0, fidx = 0;
    logic [7:0] shreg = '0;

    always @(negedge clk) begin
        s_now = scl;
        d_now = (sda === 1'b0) ? 1'b0 : 1'b1;
        if (scl_q && s_now && sda_q && !d_now) begin
            got_q.push_back(TOK_START);
            in_frame = 1'b1; bitn = 0; fidx = 0; rd_mode = 1'b0; addr_ok = 1'b0;
        end else if (scl_q && s_now && !sda_q && d_now) begin
            got_q.push_back(TOK_STOP);
            in_frame = 1'b0; bitn = 0; rd_mode = 1'b0;
        end else if (!scl_q && s_now && in_frame) begin
            if (bitn < 8) begin
                shreg = {shreg[6:0], d_now};
                bitn++;
            end else begin
                got_q.push_back(tok(shreg, d_now));
                if (fidx == 0) begin
                    addr_ok = !d_now;
                    rd_mode = !d_now && shreg[0];
                end else begin
                    rd_mode = 1'b0;
                end
                fidx++;
                bitn = 0;
            end
        end else if (scl_q && !s_now && in_frame) begin
            if (bitn == 8)
                tgt_low = !rd_mode && ((fidx == 0) ? (shreg[7:1] == tgt_addr) : addr_ok);
            else if (rd_mode)
                tgt_low = !tgt_rd_byte[7 - bitn];
            else
                tgt_low = 1'b0;
        end
        scl_q = s_now;
        sda_q = d_now;
    end

    // Driver tasks
    task automatic start_xact(input logic rd, input logic [6:0] a, input logic [7:0] r,
                              input logic [7:0] v);
        @(negedge clk);
        read = rd; addr = a; reg_id = r; reg_val = v; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cap_cyc = cyc_cnt;
    endtask

    // Returns the edge (counted from the capture edge) at which done_o is sampled high.
    task automatic wait_done(input string tag, output int done_edge);
        logic seen;
        seen = 1'b0;
        done_edge = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                done_edge = cyc_cnt - cap_cyc + 1;
            end
        end
        check({tag, "_done_seen"}, seen, 1'b1);
    endtask

    int de;
    int dc_base;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_nack", nack, 1'b0);
        check("rst_rdata", read_data, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        got_q.delete();

        // Write 7'h70 / 8'h06 / 8'h55, target ACKs everything
        start_xact(1'b0, 7'h70, 8'h06, 8'h55);
        check("wr_busy", busy, 1'b1);
        wait_done("wr", de);
        check("wr_done_cycle", de, 465);
        check("wr_nack", nack, 1'b0);
        check("wr_busy_at_done", busy, 1'b0);
        @(posedge clk); #1;
        check("wr_done_pulse", done, 1'b0);
        exp_q = '{TOK_START, tok(8'hE0, 1'b0), tok(8'h06, 1'b0), tok(8'h55, 1'b0), TOK_STOP};
        compare_bus("wr_bus");

        // Address 7'h71 not acknowledged: STOP right after first ACK slot
        start_xact(1'b0, 7'h71, 8'h06, 8'h55);
        wait_done("nk", de);
        check("nk_done_cycle", de, 177);
        check("nk_nack", nack, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("nk_nack_held", nack, 1'b1);
        exp_q = '{TOK_START, tok(8'hE2, 1'b1), TOK_STOP};
        compare_bus("nk_bus");

        // start_i during a transaction is ignored
        dc_base = done_cnt;
        start_xact(1'b0, 7'h70, 8'h06, 8'h55);
        check("ig_nack_cleared", nack, 1'b0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        addr = 7'h71; reg_id = 8'hAA; reg_val = 8'h33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ig", de);
        check("ig_done_cycle", de, 465);
        repeat (20) @(posedge clk);
        check("ig_done_count", done_cnt - dc_base, 1);
        exp_q = '{TOK_START, tok(8'hE0, 1'b0), tok(8'h06, 1'b0), tok(8'h55, 1'b0), TOK_STOP};
        compare_bus("ig_bus");

        // Reset during data-byte bit 3 (quarter 93 = bit 3, Q1: SCL low, SDA low)
        start_xact(1'b0, 7'h70, 8'h06, 8'h55);
        repeat (374) @(posedge clk);
        @(negedge clk);
        check("mr_scl_before", scl, 1'b0);
        check("mr_sda_before", sda, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_scl", scl, 1'b1);
        check("mr_sda", sda, 1'b1);
        check("mr_busy", busy, 1'b0);
        check("mr_done", done, 1'b0);
        check("mr_rdata", read_data, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        exp_q = '{TOK_START, tok(8'hE0, 1'b0), tok(8'h06, 1'b0)};
        compare_bus("mr_bus");
        start_xact(1'b0, 7'h70, 8'h06, 8'h55);
        wait_done("pr", de);
        check("pr_done_cycle", de, 465);
        check("pr_nack", nack, 1'b0);
        exp_q = '{TOK_START, tok(8'hE0, 1'b0), tok(8'h06, 1'b0), tok(8'h55, 1'b0), TOK_STOP};
        compare_bus("pr_bus");

`ifdef I2C_CONTROLLER_READ_EN
        // Register read of 8'hFE, target returns 8'hA5
        start_xact(1'b1, 7'h70, 8'hFE, 8'h00);
        wait_done("rd", de);
        check("rd_nack", nack, 1'b0);
        check("rd_data", read_data, 8'hA5);
        exp_q = '{TOK_START, tok(8'hE0, 1'b0), tok(8'hFE, 1'b0), TOK_START,
                  tok(8'hE1, 1'b0), tok(8'hA5, 1'b1), TOK_STOP};
        compare_bus("rd_bus");
`else
        // read_i is ignored: plain write on the bus, read_data_o stays zero
        start_xact(1'b1, 7'h70, 8'hFE, 8'h3C);
        wait_done("rw", de);
        check("rw_done_cycle", de, 465);
        check("rw_nack", nack, 1'b0);
        check("rw_rdata", read_data, 8'h00);
        exp_q = '{TOK_START, tok(8'hE0, 1'b0), tok(8'hFE, 1'b0), tok(8'h3C, 1'b0), TOK_STOP};
        compare_bus("rw_bus");
`endif

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
